// File: rtl/kgp_core_pkg.sv
// Shared types and defaults for the KGP RISC core front end.
// Fetch FSM encoding and the fetch buffer entry live here.
package kgp_core_pkg;

  localparam int XLEN         = 32;
  localparam int MEM_WORDS    = 32;
  localparam int RESET_PC_DEF = 0;
  localparam int FETCH_DEPTH  = 2;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry FIFO between the fetch return path and decode.
// Flush wins over push and pop in the same cycle.
module fetch_buffer
  import kgp_core_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic         valid_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency reads,
// and hands instructions to decode through a 2-entry buffer.
module instr_fetch_unit
  import kgp_core_pkg::*;
#(
  parameter int WIDTH    = XLEN,
  parameter int MEM_SIZE = MEM_WORDS,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int DEPTH    = FETCH_DEPTH
) (
  input  logic             clka,
  input  logic             rst,
  output logic             imem_rd_en,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  localparam int AW = $clog2(MEM_SIZE);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ifl_pc_q, ifl_pc_d;
  logic          inflight_q, inflight_d;
  logic [0:0]    state_q, state_d;

  logic          pop;
  logic          issue;
  logic [2:0]    occ;
  logic [1:0]    count;
  fetch_entry_t  ret_entry;
  fetch_entry_t  head;
  logic          unused_hi;

  assign pop = instr_valid & instr_ready;

  // Credit: slots committed after this cycle's pop must leave room
  assign occ = 3'(count) + 3'(inflight_q) - 3'(pop);

  assign issue = ~rst & (state_q == ST_RUN) & ~halt
               & ~redirect_valid & (occ < 3'(DEPTH));

  assign imem_rd_en = issue;
  assign imem_addr  = {{(WIDTH-AW){1'b0}}, pc_q};

  always_comb begin
    pc_d       = pc_q;
    ifl_pc_d   = ifl_pc_q;
    inflight_d = issue;
    state_d    = halt ? ST_HALTED : ST_RUN;
    if (redirect_valid) begin
      pc_d = redirect_pc[AW-1:0];
    end else if (issue) begin
      pc_d     = pc_q + AW'(1);
      ifl_pc_d = pc_q;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      pc_q       <= AW'(RESET_PC);
      ifl_pc_q   <= '0;
      inflight_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      pc_q       <= pc_d;
      ifl_pc_q   <= ifl_pc_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  // A return coinciding with a redirect is dropped by the flush
  assign ret_entry.instr = imem_data;
  assign ret_entry.pc    = {{(WIDTH-AW){1'b0}}, ifl_pc_q};

  fetch_buffer u_buf (
    .clk_i       (clka),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (inflight_q),
    .push_data_i (ret_entry),
    .pop_i       (pop),
    .count_o     (count),
    .valid_o     (instr_valid),
    .head_o      (head)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

  assign unused_hi = &{1'b0, redirect_pc[WIDTH-1:AW]};

endmodule
